// File: rtl/aes_pkg.sv
// Shared AES definitions: state/byte widths, FSM encoding and the
// column-major (row, col) to byte-index mapping.
package aes_pkg;

    localparam int STATE_W = 128;
    localparam int BYTE_W  = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Byte i of the state sits at row i%4, column i/4.
    function automatic int byte_idx(input int row, input int col);
        return col * 4 + row;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box. This is the mirror of the inverse S-box
// used on the decryption path.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [BYTE_W-1:0] in_byte,
    output logic [BYTE_W-1:0] out_byte
);

    // Element 0 is the leftmost byte, so the table reads row by row.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign out_byte = SBOX[in_byte];

endmodule

// File: rtl/aes_sub_shift.sv
// AES SubBytes followed by ShiftRows on one 128-bit state per transaction.
// SBOX_LANES bytes are substituted per cycle, and the result is held until it is taken.
module aes_sub_shift
    import aes_pkg::*;
#(
    parameter int SBOX_LANES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [STATE_W-1:0]   in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [STATE_W-1:0]   out_data
);

    localparam int NUM_STEPS = 16 / SBOX_LANES;
    localparam int CNT_W     = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;

    if (!(SBOX_LANES == 1 || SBOX_LANES == 2 || SBOX_LANES == 4 ||
          SBOX_LANES == 8 || SBOX_LANES == 16)) begin : g_bad_lanes
        $error("aes_sub_shift: SBOX_LANES must be 1, 2, 4, 8 or 16");
    end

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [STATE_W-1:0]   work_q, work_d;
    logic [STATE_W-1:0]   out_q, out_d;
    logic [BYTE_W-1:0]    lane_in  [SBOX_LANES];
    logic [BYTE_W-1:0]    lane_out [SBOX_LANES];

    function automatic logic [3:0] lane_idx(input logic [CNT_W-1:0] cnt, input int lane);
        return 4'(int'(cnt) * SBOX_LANES + lane);
    endfunction

    // ShiftRows: output byte (r,c) takes working byte (r,(c+r) mod 4).
    function automatic logic [STATE_W-1:0] shift_rows(input logic [STATE_W-1:0] s);
        logic [STATE_W-1:0] res;
        res = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                res[STATE_W-1-BYTE_W*byte_idx(r, c) -: BYTE_W] =
                    s[STATE_W-1-BYTE_W*byte_idx(r, (c + r) % 4) -: BYTE_W];
            end
        end
        return res;
    endfunction

    always_comb begin
        for (int g = 0; g < SBOX_LANES; g++) begin
            lane_in[g] = work_q[STATE_W-1-BYTE_W*int'(lane_idx(cnt_q, g)) -: BYTE_W];
        end
    end

    for (genvar g = 0; g < SBOX_LANES; g++) begin : g_lane
        aes_sbox u_sbox (
            .in_byte  (lane_in[g]),
            .out_byte (lane_out[g])
        );
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        work_d    = work_q;
        out_d     = out_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    work_d  = in_data;
                    cnt_d   = '0;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                for (int g = 0; g < SBOX_LANES; g++) begin
                    work_d[STATE_W-1-BYTE_W*int'(lane_idx(cnt_q, g)) -: BYTE_W] = lane_out[g];
                end
                if (cnt_q == CNT_W'(NUM_STEPS - 1)) begin
                    // The result register is loaded from the fully substituted state.
                    cnt_d   = '0;
                    out_d   = shift_rows(work_d);
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
        end
    end

    always_ff @(posedge clk) begin
        work_q <= work_d;
    end

    assign out_data = out_q;

endmodule

// File: tb/tb_aes_sub_shift.sv
// Directed bench for aes_sub_shift at 4, 1 and 16 lanes and for aes_sbox.
// It uses an algorithmic GF(2^8) reference model.
module tb_aes_sub_shift;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid  [3];
    logic         in_ready  [3];
    logic [127:0] in_data   [3];
    logic         out_valid [3];
    logic         out_ready [3];
    logic [127:0] out_data  [3];
    logic [7:0]   sb_in, sb_out;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    aes_sub_shift #(.SBOX_LANES(4)) u_dut4 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]));
    aes_sub_shift #(.SBOX_LANES(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]));
    aes_sub_shift #(.SBOX_LANES(16)) u_dut16 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_data(in_data[2]),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_data(out_data[2]));
    aes_sbox u_sbox (.in_byte(sb_in), .out_byte(sb_out));

    typedef struct {
        string        name;
        logic [127:0] din;
        logic [127:0] exp;
    } vec_t;

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    function automatic logic [7:0] sbox_ref(input logic [7:0] x);
        logic [7:0] inv;
        inv = 8'h01;
        if (x == 8'h00) inv = 8'h00;
        else for (int i = 0; i < 254; i++) inv = gmul(inv, x);
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [127:0] ref_ss(input logic [127:0] s);
        logic [7:0]   b [16];
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++) b[i] = sbox_ref(s[127-8*i -: 8]);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                o[127-8*(c*4+r) -: 8] = b[((c+r)%4)*4+r];
        return o;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic wait_idle(input int d);
        int n = 0;
        @(negedge clk);
        while (!in_ready[d] && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("wait_idle", 128'(in_ready[d]), 128'd1);
    endtask

    // Accept at one edge, scramble in_data, then measure latency and result.
    task automatic send(input int d, input string name, input logic [127:0] din,
                        input logic [127:0] exp, input int exp_lat);
        int lat = 0;
        out_ready[d] = 1'b1;
        wait_idle(d);
        in_valid[d] = 1'b1;
        in_data[d]  = din;
        @(posedge clk);
        #1;
        in_valid[d] = 1'b0;
        in_data[d]  = ~din;
        while (!out_valid[d] && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({name, "_lat"}, 128'(lat), 128'(exp_lat));
        check({name, "_data"}, out_data[d], exp);
    endtask

    vec_t vecs [4];
    logic [127:0] v0, v1, v2, exp_hold;
    logic [127:0] blk [3];
    int acc_cyc [3];
    int out_cyc [3];

    initial begin
        for (int d = 0; d < 3; d++) begin
            in_valid[d] = 1'b0; in_data[d] = '0; out_ready[d] = 1'b1;
        end
        sb_in = 8'h00;
        vecs[0] = '{"fips_b1", 128'h193de3bea0f4e22b9ac68d2ae9f84808, 128'hd4bf5d30e0b452aeb84111f11e2798e5};
        vecs[1] = '{"zeros",   128'h0, {16{8'h63}}};
        vecs[2] = '{"ones",    {16{8'hff}}, {16{8'h16}}};
        vecs[3] = '{"ramp",    128'h000102030405060708090a0b0c0d0e0f, 128'h636b6776f201ab7b30d777c5fe7c6f2b};

        // Reset state of all three configurations
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++)
            check("reset_state", {in_ready[d], out_valid[d], out_data[d]}, {1'b1, 1'b0, 128'h0});
        rst = 1'b0;

        // S-box sweep and spot values
        for (int i = 0; i < 256; i++) begin
            sb_in = 8'(i);
            #1;
            check("sbox_sweep", 128'(sb_out), 128'(sbox_ref(8'(i))));
        end
        sb_in = 8'h00; #1; check("sbox_00", 128'(sb_out), 128'h63);
        sb_in = 8'h53; #1; check("sbox_53", 128'(sb_out), 128'hed);
        sb_in = 8'hff; #1; check("sbox_ff", 128'(sb_out), 128'h16);
        sb_in = 8'h63; #1; check("sbox_63", 128'(sb_out), 128'hfb);

        for (int k = 0; k < 4; k++) send(0, vecs[k].name, vecs[k].din, vecs[k].exp, 4);

        send(1, "zeros_l1",  128'h0, {16{8'h63}}, 16);
        send(2, "zeros_l16", 128'h0, {16{8'h63}}, 1);

        // Backpressure: result held while a second in_valid waits
        v0 = 128'h00112233445566778899aabbccddeeff;
        v1 = 128'h3243f6a8885a308d313198a2e0370734;
        exp_hold = ref_ss(v0);
        wait_idle(0);
        out_ready[0] = 1'b0;
        in_valid[0]  = 1'b1;
        in_data[0]   = v0;
        @(posedge clk);
        #1;
        in_data[0] = v1;
        begin
            int lat = 0;
            while (!out_valid[0] && lat < 40) begin
                @(posedge clk); #1; lat++;
            end
            check("bp_lat", 128'(lat), 128'd4);
        end
        check("bp_data", out_data[0], exp_hold);
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            check("bp_hold", {out_valid[0], in_ready[0], out_data[0]}, {1'b1, 1'b0, exp_hold});
        end
        @(negedge clk);
        out_ready[0] = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release", {in_ready[0], out_valid[0]}, 128'b10);
        @(posedge clk);
        #1;
        in_valid[0] = 1'b0;
        begin
            int lat = 0;
            while (!out_valid[0] && lat < 40) begin
                @(posedge clk); #1; lat++;
            end
            check("bp_second_lat", 128'(lat), 128'd4);
        end
        check("bp_second_data", out_data[0], ref_ss(v1));

        // Reset asserted during the second BUSY cycle
        v2 = 128'hdeadbeef0123456789abcdeffedcba98;
        wait_idle(0);
        in_valid[0] = 1'b1;
        in_data[0]  = v2;
        @(posedge clk);
        #1;
        in_valid[0] = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_midop", {in_ready[0], out_valid[0], out_data[0]}, {1'b1, 1'b0, 128'h0});
        rst = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            check("rst_no_result", 128'(out_valid[0]), 128'd0);
        end
        send(0, "after_rst", vecs[0].din, vecs[0].exp, 4);

        // Back-to-back: three random blocks with in_valid held high
        for (int k = 0; k < 3; k++)
            blk[k] = {$urandom, $urandom, $urandom, $urandom};
        wait_idle(0);
        out_ready[0] = 1'b1;
        begin
            int cyc = 0, idx = 0, oidx = 0;
            logic acc;
            while (oidx < 3 && cyc < 100) begin
                if (cyc > 0) @(negedge clk);
                in_valid[0] = (idx < 3);
                in_data[0]  = blk[(idx < 3) ? idx : 0];
                acc = in_valid[0] && in_ready[0];
                @(posedge clk);
                cyc++;
                if (acc) begin
                    acc_cyc[idx] = cyc;
                    idx++;
                end
                #1;
                if (out_valid[0]) begin
                    check("b2b_data", out_data[0], ref_ss(blk[oidx]));
                    out_cyc[oidx] = cyc;
                    oidx++;
                end
            end
            in_valid[0] = 1'b0;
            check("b2b_count", 128'(oidx), 128'd3);
            if (oidx == 3) begin
                check("b2b_first_lat", 128'(out_cyc[0] - acc_cyc[0]), 128'd4);
                for (int k = 1; k < 3; k++)
                    check("b2b_period", 128'(out_cyc[k] - out_cyc[k-1]), 128'd6);
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
